vec_store_seq: RTL and testbench

VEC_STORE_SEQ -- requirements
Module: vec_store_seq

---
 rtl/vec_pkg.sv | 6 +
 rtl/vec_store_seq.sv | 67 ++++++
 tb/tb_vec_store_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// vec_pkg: shared vector-store sizes and FSM state encoding
package vec_pkg;
  localparam int N_LANES = 16;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
endpackage

// File: rtl/vec_store_seq.sv
// vec_store_seq: latches a vector and writes it lane by lane to memory with a ready handshake
module vec_store_seq #(
  parameter int N_LANES = vec_pkg::N_LANES,
  parameter int WORD_W = vec_pkg::WORD_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WORD_W-1:0]               base_addr,
  input  logic [N_LANES-1:0][WORD_W-1:0]  a_res,
  input  logic                            mem_ready,
  output logic                            mem_we,
  output logic [WORD_W-1:0]               mem_addr,
  output logic [WORD_W-1:0]               mem_wdata,
  output logic                            busy,
  output logic                            done
);
  import vec_pkg::*;
  localparam int IW = N_LANES > 1 ? $clog2(N_LANES) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [IW-1:0] nidx;
  logic [N_LANES-1:0][WORD_W-1:0] lat;
  assign nidx = idx + IW'(1);
  // mem_addr doubles as the running base+4*idx so no separate base register is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      lat <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= WRITE;
          lat <= a_res;
          idx <= '0;
          mem_we <= 1'b1;
          mem_addr <= base_addr;
          mem_wdata <= a_res[0];
          busy <= 1'b1;
        end
        WRITE: if (mem_ready) begin
          if (idx == IW'(N_LANES - 1)) begin
            state <= DONE;
            mem_we <= 1'b0;
            done <= 1'b1;
          end else begin
            idx <= nidx;
            mem_addr <= mem_addr + WORD_W'(4);
            mem_wdata <= lat[nidx];
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_store_seq.sv
// tb_vec_store_seq: directed and random stimulus against a write-queue reference model
module tb_vec_store_seq;
  import vec_pkg::*;
  logic clk = 1'b0;
  logic rst, start, mem_ready;
  logic [WORD_W-1:0] base_addr;
  logic [N_LANES-1:0][WORD_W-1:0] a_res;
  logic mem_we, busy, done;
  logic [WORD_W-1:0] mem_addr, mem_wdata;
  vec_store_seq dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .a_res(a_res),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] d;
  } wr_t;
  wr_t wq[$];
  bit done_now;
  int errors, checks, cyc, done_cyc, nwr;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic rand_vec();
    for (int i = 0; i < N_LANES; i++) a_res[i] = $urandom;
  endtask
  // sample at negedge, then advance the reference model by the inputs of this cycle
  task automatic step();
    bit idle, nd;
    @(negedge clk);
    chk("we", 64'(mem_we), 64'(wq.size() > 0));
    if (wq.size() > 0) begin
      chk("addr", 64'(mem_addr), 64'(wq[0].a));
      chk("wdata", 64'(mem_wdata), 64'(wq[0].d));
    end
    chk("done", 64'(done), 64'(done_now));
    chk("busy", 64'(busy), 64'(wq.size() > 0 || done_now));
    if (done) done_cyc = cyc;
    if (mem_we && mem_ready) nwr++;
    idle = wq.size() == 0 && !done_now;
    if (rst) begin
      wq.delete();
      done_now = 1'b0;
    end else begin
      nd = wq.size() == 1 && mem_ready;
      if (wq.size() > 0 && mem_ready) void'(wq.pop_front());
      done_now = nd;
      if (idle && start)
        for (int i = 0; i < N_LANES; i++) wq.push_back('{base_addr + WORD_W'(4 * i), a_res[i]});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic begin_store(input logic [WORD_W-1:0] b);
    base_addr = b;
    start = 1'b1;
    cyc = 0;
    done_cyc = -1;
    nwr = 0;
    step();
    start = 1'b0;
  endtask
  initial begin
    errors = 0; checks = 0; cyc = 0; done_cyc = -1; nwr = 0; done_now = 1'b0;
    rst = 1'b1; start = 1'b1; mem_ready = 1'b1; base_addr = 32'h55; rand_vec();
    repeat (3) step();
    chk("rst_addr", 64'(mem_addr), 64'h0);
    chk("rst_wdata", 64'(mem_wdata), 64'h0);
    rst = 1'b0; start = 1'b0;
    step();
    // basic store, then immediate restart on the cycle after done
    for (int i = 0; i < N_LANES; i++) a_res[i] = WORD_W'(i + 1);
    begin_store(32'h100);
    for (int c = 1; c <= N_LANES + 1; c++) begin rand_vec(); base_addr = $urandom; step(); end
    chk("done_cyc_basic", 64'(done_cyc), 64'(N_LANES + 1));
    chk("nwr_basic", 64'(nwr), 64'(N_LANES));
    rand_vec();
    begin_store(32'h2000);
    for (int c = 1; c <= N_LANES + 3; c++) step();
    chk("done_cyc_restart", 64'(done_cyc), 64'(N_LANES + 1));
    // backpressure in cycles 3-5
    for (int i = 0; i < N_LANES; i++) a_res[i] = WORD_W'(i + 1);
    begin_store(32'h100);
    for (int c = 1; c <= N_LANES + 7; c++) begin
      mem_ready = !(c >= 3 && c <= 5);
      if (c == 3) chk("held_addr", 64'(mem_addr), 64'h108);
      step();
    end
    mem_ready = 1'b1;
    chk("done_cyc_stall", 64'(done_cyc), 64'(N_LANES + 4));
    chk("nwr_stall", 64'(nwr), 64'(N_LANES));
    // address wrap
    rand_vec();
    begin_store(32'hFFFF_FFF8);
    for (int c = 1; c <= N_LANES + 3; c++) begin
      if (c == N_LANES) chk("wrap_last", 64'(mem_addr), 64'h34);
      step();
    end
    // second start while busy is ignored
    rand_vec();
    begin_store(32'h400);
    for (int c = 1; c <= N_LANES + 3; c++) begin
      if (c == 5) begin start = 1'b1; rand_vec(); base_addr = 32'h9000; end
      step();
      start = 1'b0;
    end
    chk("done_cyc_ignore", 64'(done_cyc), 64'(N_LANES + 1));
    chk("nwr_ignore", 64'(nwr), 64'(N_LANES));
    // reset mid-store aborts with no done
    rand_vec();
    begin_store(32'h800);
    for (int c = 1; c <= N_LANES + 6; c++) begin
      rst = c == 6;
      if (c == 7) begin
        chk("abort_we", 64'(mem_we), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
      end
      step();
    end
    rst = 1'b0;
    chk("abort_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    // random traffic
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(3) == 0);
      mem_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(99) == 0);
      base_addr = $urandom;
      rand_vec();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
